// File: rtl/pcileech_sysctl_ledbtn_if.sv
// Board-control signal bundle between the pads/core (master) and pcileech_sysctl_ledbtn (slave).
interface pcileech_sysctl_ledbtn_if #(
    parameter int NUM_BTN = 2,
    parameter int NUM_LED = 2
);
    logic [NUM_BTN-1:0]   btn_n;
    logic [NUM_BTN-1:0]   btn_level;
    logic [NUM_BTN-1:0]   btn_press;
    logic                 sys_rst;
    logic [2*NUM_LED-1:0] led_mode;
    logic [NUM_LED-1:0]   led_act;
    logic                 led_invert;
    logic [NUM_LED-1:0]   led;

    modport master (
        output btn_n, led_mode, led_act, led_invert,
        input  btn_level, btn_press, sys_rst, led
    );

    modport slave (
        input  btn_n, led_mode, led_act, led_invert,
        output btn_level, btn_press, sys_rst, led
    );
endinterface

// File: rtl/pcileech_sysctl_ledbtn.sv
// Button debounce, stretched system-reset sequencer and LED mode engine.
// Define PCILEECH_SYSCTL_LONGPRESS_RST_EN to enable the button-0 long-press reset.
module pcileech_sysctl_ledbtn #(
    parameter int NUM_BTN           = 2,
    parameter int NUM_LED           = 2,
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int RST_HOLD_CYCLES   = 16,
    parameter int LONGPRESS_CYCLES  = 200000000,
    parameter int STRETCH_CYCLES    = 5000000,
    parameter int BLINK_HALF_CYCLES = 25000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pcileech_sysctl_ledbtn_if.slave bus
);
    localparam int DB_W   = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = ($clog2(RST_HOLD_CYCLES) < 1) ? 1 : $clog2(RST_HOLD_CYCLES);
    localparam int ST_W   = $clog2(STRETCH_CYCLES + 1);
    localparam int BL_W   = ($clog2(BLINK_HALF_CYCLES) < 1) ? 1 : $clog2(BLINK_HALF_CYCLES);

`ifdef PCILEECH_SYSCTL_LONGPRESS_RST_EN
    localparam int LP_W  = ($clog2(LONGPRESS_CYCLES) < 1) ? 1 : $clog2(LONGPRESS_CYCLES);
    localparam int CNT_W = (LP_W > HOLD_W) ? LP_W : HOLD_W;
    typedef enum logic [1:0] {S_HOLD, S_RUN, S_ARMED} state_e;
`else
    // LONGPRESS_CYCLES has no effect without the long-press path
    localparam int CNT_W = HOLD_W + 0 * LONGPRESS_CYCLES;
    typedef enum logic {S_HOLD, S_RUN} state_e;
`endif

    logic [NUM_BTN-1:0]           sync1_q, sync2_q, pressed;
    logic [NUM_BTN-1:0]           level_q, level_d, press_q, press_d;
    logic [NUM_BTN-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         sys_rst_q;
    logic [NUM_LED-1:0][ST_W-1:0] st_cnt_q, st_cnt_d;
    logic [BL_W-1:0]              bl_cnt_q, bl_cnt_d;
    logic                         phase_q, phase_d;
    logic [NUM_LED-1:0]           led_q, led_d;

    assign pressed = ~sync2_q;

    always_comb begin
        level_d  = level_q;
        press_d  = '0;
        db_cnt_d = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (pressed[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_d[i] = pressed[i];
                    press_d[i] = pressed[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_HOLD: begin
                if (cnt_q == CNT_W'(RST_HOLD_CYCLES - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
`ifdef PCILEECH_SYSCTL_LONGPRESS_RST_EN
                if (!level_q[0]) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(LONGPRESS_CYCLES - 1)) begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                cnt_d = '0;
`endif
            end
`ifdef PCILEECH_SYSCTL_LONGPRESS_RST_EN
            // Reset fires on release so one hold yields exactly one reset
            S_ARMED: begin
                cnt_d = '0;
                if (!level_q[0]) state_d = S_HOLD;
            end
`endif
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        st_cnt_d = st_cnt_q;
        for (int unsigned i = 0; i < NUM_LED; i++) begin
            if (bus.led_act[i]) begin
                st_cnt_d[i] = ST_W'(STRETCH_CYCLES);
            end else if (st_cnt_q[i] != '0) begin
                st_cnt_d[i] = st_cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        bl_cnt_d = bl_cnt_q + 1'b1;
        phase_d  = phase_q;
        if (bl_cnt_q == BL_W'(BLINK_HALF_CYCLES - 1)) begin
            bl_cnt_d = '0;
            phase_d  = ~phase_q;
        end
    end

    // Stretch mode looks at the next counter value so a strobe lights the LED immediately
    always_comb begin
        led_d = '0;
        for (int unsigned i = 0; i < NUM_LED; i++) begin
            case (bus.led_mode[2*i +: 2])
                2'b00:   led_d[i] = 1'b0;
                2'b01:   led_d[i] = 1'b1;
                2'b10:   led_d[i] = (st_cnt_d[i] != '0);
                default: led_d[i] = phase_q;
            endcase
            led_d[i] = led_d[i] ^ bus.led_invert;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            level_q   <= '0;
            press_q   <= '0;
            db_cnt_q  <= '0;
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            sys_rst_q <= 1'b1;
            st_cnt_q  <= '0;
            bl_cnt_q  <= '0;
            phase_q   <= 1'b0;
            led_q     <= '0;
        end else begin
            sync1_q   <= bus.btn_n;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sys_rst_q <= (state_q == S_HOLD);
            st_cnt_q  <= st_cnt_d;
            bl_cnt_q  <= bl_cnt_d;
            phase_q   <= phase_d;
            led_q     <= led_d;
        end
    end

    assign bus.btn_level = level_q;
    assign bus.btn_press = press_q;
    assign bus.sys_rst   = sys_rst_q;
    assign bus.led       = led_q;
endmodule

// File: doc/pcileech_sysctl_ledbtn.md
# pcileech_sysctl_ledbtn

Parametrised board-control block that takes over button, LED and reset glue from the board top-levels. It debounces N active-low push buttons, sequences a stretched system reset for `pcileech_com`, `pcileech_fifo` and `pcileech_pcie_a7`, and drives M user LEDs in selectable modes (off, on, activity-stretch, blink) with global inversion. Each board top instantiates one copy between its pads and the core modules.

## Interface

Parameters:
- `NUM_BTN`, default 2: number of buttons, range 1..8.
- `NUM_LED`, default 2: number of LEDs, range 1..8.
- `DEBOUNCE_CYCLES`, default 1000000: stable cycles required to accept a button change (10 ms at 100 MHz); minimum 2.
- `RST_HOLD_CYCLES`, default 16: `sys_rst` assertion length; minimum 1.
- `LONGPRESS_CYCLES`, default 200000000: button-0 hold time that triggers a reset (2 s).
- `STRETCH_CYCLES`, default 5000000: activity on-time (50 ms); minimum 1.
- `BLINK_HALF_CYCLES`, default 25000000: blink half-period; minimum 1.

Ports:
- `clk` in 1: system clock (100 MHz). This is the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `btn_n` in NUM_BTN: raw button pads, asynchronous, active-low.
- `btn_level` out NUM_BTN: debounced state; 1 = pressed.
- `btn_press` out NUM_BTN: one-cycle pulse on each debounced press.
- `sys_rst` out 1: active-high reset to downstream modules.
- `led_mode` in 2*NUM_LED: per-LED mode, bits [2i+1:2i]. 00 = off, 01 = on, 10 = activity stretch, 11 = blink.
- `led_act` in NUM_LED: activity strobes, one per LED.
- `led_invert` in 1: inverts all LED outputs.
- `led` out NUM_LED: LED drive, registered.

## Operation

**Input sync**
- Each `btn_n` bit passes through a 2-flop synchronizer.
- Synchronizer reset value is 1 (released).
- The synchronized value is inverted to give `pressed`.

**Debounce (per button)**
- Counter width: clog2(DEBOUNCE_CYCLES).
- While `pressed != btn_level`, the counter increments.
- When the counter reaches DEBOUNCE_CYCLES-1, `btn_level` takes `pressed` and the counter clears.
- Any cycle with `pressed == btn_level` clears the counter, so a glitch restarts the count.
- `btn_press` is 1 for exactly one cycle: the cycle where `btn_level` goes 0→1. Releases produce no pulse.

**Reset sequencer FSM**
- States: HOLD, RUN, ARMED.
- HOLD:
  - `sys_rst` = 1 and the hold counter increments.
  - At RST_HOLD_CYCLES-1, go to RUN.
- RUN:
  - `sys_rst` = 0.
  - The long-press counter counts while `btn_level[0]` = 1 and clears when it is 0.
  - At LONGPRESS_CYCLES-1, go to ARMED.
- ARMED:
  - `sys_rst` = 0.
  - When `btn_level[0]` = 0, go to HOLD with the counter cleared.
  - The reset fires on release, so a single hold produces exactly one reset.
- `rst_n` = 0 forces HOLD with the counter at 0. `sys_rst` therefore stays 1 throughout `rst_n` low.
- `sys_rst` does not reset this block.

**LED engine**
- Stretch counter (one per LED):
  - `led_act[i]` = 1 loads STRETCH_CYCLES.
  - Otherwise the counter decrements while nonzero.
  - A re-strobe while running reloads the counter.
  - The counter runs in all modes; only mode 10 displays it.
- Blink:
  - A single shared counter toggles a shared `phase` bit every BLINK_HALF_CYCLES cycles.
  - `phase` resets to 0, so all blinking LEDs are in phase.
- Output:
  - `led[i]` registers `f(mode) ^ led_invert`.
  - Mode 00 gives 0, mode 01 gives 1, mode 10 gives (stretch counter != 0), mode 11 gives `phase`.
  - When `led_act` is strobed, the next-cycle output uses the freshly loaded counter value.

**Reset values (`rst_n` = 0)**
- `btn_level` = 0, `btn_press` = 0, `sys_rst` = 1, `led` = 0.
- `led` is 0 regardless of `led_invert`.
- All counters = 0, `phase` = 0.

## Timing

- Button to level: stable raw change → `btn_level` update after 2 (sync) + DEBOUNCE_CYCLES cycles.
- Button to pulse: `btn_press` asserts in the same cycle as `btn_level` rises.
- Reset release:
  - `rst_n` is first sampled high at edge k.
  - `sys_rst` is 1 for exactly RST_HOLD_CYCLES edges starting at k and falls at edge k+RST_HOLD_CYCLES.
- LED latency: one cycle from `led_mode`, `led_act` and `led_invert`.
- Stretch on-time: a single `led_act` pulse at edge t gives `led` = 1 from t+1 for exactly STRETCH_CYCLES cycles.
- Blink: period 2*BLINK_HALF_CYCLES with 50% duty.
- Simultaneous events:
  - `rst_n` low overrides all other inputs.
  - A reload on `led_act` beats the decrement.
  - A long-press release coinciding with `rst_n` low leaves the FSM in HOLD from reset.

## Configuration

`PCILEECH_SYSCTL_LONGPRESS_RST_EN`:
- Defined: the FSM implements the RUN→ARMED→HOLD long-press path on button 0.
- Undefined:
  - The FSM has only HOLD and RUN, and the long-press counter is not synthesized.
  - Button 0 is a plain debounced input.
  - `sys_rst` is driven solely by `rst_n`.

## Test plan

The bench uses DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=3, LONGPRESS_CYCLES=10, STRETCH_CYCLES=5, BLINK_HALF_CYCLES=4.

- **Reset release:** `rst_n` low 5 cycles then high → `sys_rst` = 1 during low plus exactly 3 cycles, then 0; `led` = 0 during reset even with `led_invert` = 1.
- **Debounce:** `btn_n[1]` low for 3 cycles, high 1 cycle, then low for 8 cycles → no change on the 3-cycle glitch; `btn_level[1]` rises 6 cycles (2 sync + 4) after the final low edge, with a single-cycle `btn_press[1]`.
- **Activity stretch:** mode 10, `led_act` pulse at t → `led` high t+1..t+5. A second pulse at t+3 → high through t+8.
- **Blink:** mode 11 on both LEDs → both toggle together every 4 cycles; `led_invert` = 1 → inverted one cycle later.
- **Long-press (macro defined):** button 0 held 20 debounced cycles → `sys_rst` stays 0 while held; on debounced release `sys_rst` = 1 for 3 cycles exactly once.
- **Long-press (macro undefined):** same stimulus → `sys_rst` stays 0 throughout.
